// File: rtl/iguana_uart_rx.sv
// UART receiver: 2-FF synchroniser, 8N1 deserialiser and a small receive FIFO
// delivering bytes over a valid/ready stream.
// Define IGUANA_UART_RX_PARITY_EN to add an even-parity bit (8E1) and enable parity_err_o.
module iguana_uart_rx #(
    parameter int unsigned ClksPerBit = 868,
    parameter int unsigned DataBits   = 8,
    parameter int unsigned FifoDepth  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam int unsigned BitW = $clog2(DataBits);
    localparam int unsigned PtrW = $clog2(FifoDepth);

    localparam logic [CntW-1:0] CntMid   = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] CntEnd   = CntW'(ClksPerBit - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(DataBits - 1);
    localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FifoDepth);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
`ifdef IGUANA_UART_RX_PARITY_EN
        , StParity
`endif
    } state_e;

    logic                r_sync1, r_sync2;
    logic                w_rx_s;
    state_e              r_state, w_state_d;
    logic [CntW-1:0]     r_cnt;
    logic [BitW-1:0]     r_bit_idx;
    logic [DataBits-1:0] r_shift;
    logic                w_mid, w_end;
    logic                w_push, w_frame_err, w_parity_err;
    logic                r_frame_err, r_parity_err;
    logic [7:0]          w_byte;
`ifdef IGUANA_UART_RX_PARITY_EN
    logic                r_par_err;
`endif

    logic [7:0]          r_mem [FifoDepth];
    logic [PtrW-1:0]     r_wptr, r_rptr;
    logic [PtrW:0]       r_count;
    logic                w_pop, w_full, w_wr;

    assign w_rx_s = r_sync2;
    assign w_mid  = (r_cnt == CntMid);
    assign w_end  = (r_cnt == CntEnd);

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state decode and single-cycle push/error strobes.
    always_comb begin
        w_state_d    = r_state;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_rx_s) w_state_d = StStart;
            end
            StStart: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (w_mid && w_rx_s) w_state_d = StIdle;
                else if (w_end)      w_state_d = StData;
            end
            StData: begin
                if (w_end && (r_bit_idx == BitLast)) begin
`ifdef IGUANA_UART_RX_PARITY_EN
                    w_state_d = StParity;
`else
                    w_state_d = StStop;
`endif
                end
            end
`ifdef IGUANA_UART_RX_PARITY_EN
            StParity: begin
                if (w_end) w_state_d = StStop;
            end
`endif
            StStop: begin
                // Leave at mid stop bit so a directly following start bit is caught.
                if (w_mid) begin
                    if (w_rx_s) begin
`ifdef IGUANA_UART_RX_PARITY_EN
                        if (r_par_err) w_parity_err = 1'b1;
                        else           w_push       = 1'b1;
`else
                        w_push = 1'b1;
`endif
                        w_state_d = StIdle;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_d   = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                if (w_rx_s) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // FSM state, bit-period counter, data shifter and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
`ifdef IGUANA_UART_RX_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;
            if ((w_state_d != r_state) || (r_state == StIdle) || (r_state == StWaitIdle)) begin
                r_cnt <= '0;
            end else if (w_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == StStart) begin
                r_bit_idx <= '0;
`ifdef IGUANA_UART_RX_PARITY_EN
                r_par_err <= 1'b0;
`endif
            end
            if (r_state == StData) begin
                if (w_mid) r_shift   <= {w_rx_s, r_shift[DataBits-1:1]};
                if (w_end) r_bit_idx <= r_bit_idx + 1'b1;
            end
`ifdef IGUANA_UART_RX_PARITY_EN
            if ((r_state == StParity) && w_mid) r_par_err <= (w_rx_s != ^r_shift);
`endif
        end
    end

    // Zero-extend the received word to the 8-bit FIFO entry.
    always_comb begin
        w_byte                 = '0;
        w_byte[DataBits-1:0]   = r_shift;
    end

    assign valid_o     = (r_count != '0);
    assign w_pop       = valid_o && ready_i;
    assign w_full      = (r_count == FifoFull);
    assign w_wr        = w_push && (!w_full || w_pop);
    assign overflow_o  = w_push && w_full && !w_pop;
    assign data_o      = valid_o ? r_mem[r_rptr] : 8'h00;
    assign busy_o      = (r_state != StIdle);
    assign frame_err_o = r_frame_err;
`ifdef IGUANA_UART_RX_PARITY_EN
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written, the output is gated by valid_o.
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= w_byte;
    end

`ifndef IGUANA_UART_RX_PARITY_EN
    logic w_unused;
    assign w_unused = r_parity_err;
`endif

endmodule

// File: tb/tb_iguana_uart_rx.sv
// Directed self-checking bench for iguana_uart_rx (ClksPerBit=16, DataBits=8, FifoDepth=4).
module tb_iguana_uart_rx;

    localparam int unsigned Cpb = 16;
`ifdef IGUANA_UART_RX_PARITY_EN
    localparam bit ParEn  = 1'b1;
    localparam int LatCyc = (1 + 8 + 1) * Cpb + Cpb / 2 + 1 + 2;
`else
    localparam bit ParEn  = 1'b0;
    localparam int LatCyc = (1 + 8) * Cpb + Cpb / 2 + 1 + 2;
`endif

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       parity_err_o;
    logic       overflow_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_low    = 0;
    int last_rise = 0;
    int n_ferr = 0, n_perr = 0, n_ovf = 0;
    logic prev_valid = 1'b0;
    logic [7:0] popped[$];

    iguana_uart_rx #(
        .ClksPerBit(Cpb),
        .DataBits  (8),
        .FifoDepth (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .parity_err_o(parity_err_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe pulses and pops away from the active edge.
    always @(negedge clk) begin
        if (frame_err_o)  n_ferr <= n_ferr + 1;
        if (parity_err_o) n_perr <= n_perr + 1;
        if (overflow_o)   n_ovf  <= n_ovf + 1;
        if (valid_o && ready_i) popped.push_back(data_o);
        if (valid_o && !prev_valid) last_rise <= cyc;
        prev_valid <= valid_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_i = b;
        wait_cyc(Cpb);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop; line left at the stop level.
    task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
        t_low = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (ParEn) send_bit(par_b);
        send_bit(stop_b);
    endtask

    task automatic check_pop(input string tag, input int idx, input logic [7:0] exp);
        logic [31:0] v;
        v = (idx < popped.size()) ? {24'h0, popped[idx]} : 32'hDEAD;
        check(tag, v, {24'h0, exp});
    endtask

    initial begin
        int ferr0, ovf0, perr0;
        rst_ni  = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        wait_cyc(3);
        check("rst_data",  data_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ferr",  frame_err_o, 0);
        check("rst_perr",  parity_err_o, 0);
        check("rst_ovf",   overflow_o, 0);
        check("rst_busy",  busy_o, 0);
        rst_ni = 1'b1;
        wait_cyc(5);

        // Single byte with ready held high.
        ready_i = 1'b1;
        popped.delete();
        send_frame(8'hA5, ^8'hA5, 1'b1);
        wait_cyc(20);
        check("single_cnt",  popped.size(), 1);
        check_pop("single_data", 0, 8'hA5);
        check("single_lat",  last_rise - t_low, LatCyc);
        check("single_ferr", n_ferr, 0);
        check("single_ovf",  n_ovf, 0);
        check("single_perr", n_perr, 0);
        check("single_busy", busy_o, 0);
        check("single_vld",  valid_o, 0);

        // Back-to-back frames buffered under backpressure, then drained.
        ready_i = 1'b0;
        popped.delete();
        send_frame(8'h00, ^8'h00, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        wait_cyc(5);
        check("b2b_valid", valid_o, 1);
        check("b2b_head",  data_o, 8'h00);
        wait_cyc(10);
        check("b2b_hold",  data_o, 8'h00);
        ready_i = 1'b1;
        wait_cyc(6);
        ready_i = 1'b0;
        check("b2b_cnt", popped.size(), 3);
        check_pop("b2b_0", 0, 8'h00);
        check_pop("b2b_1", 1, 8'hFF);
        check_pop("b2b_2", 2, 8'h3C);
        check("b2b_empty", valid_o, 0);

        // Overflow on the fifth byte into a depth-4 FIFO.
        ovf0 = n_ovf;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), ^8'(i), 1'b1);
        wait_cyc(3);
        check("ovf_none4", n_ovf - ovf0, 0);
        send_frame(8'h05, ^8'h05, 1'b1);
        wait_cyc(3);
        check("ovf_one",  n_ovf - ovf0, 1);
        check("ovf_head", data_o, 8'h01);
        popped.delete();
        ready_i = 1'b1;
        wait_cyc(8);
        ready_i = 1'b0;
        check("ovf_cnt", popped.size(), 4);
        for (int i = 0; i < 4; i++) check_pop("ovf_data", i, 8'(i + 1));

        // Framing error followed by a 40-bit break, then a clean frame.
        ferr0 = n_ferr;
        send_frame(8'h55, ^8'h55, 1'b0);
        wait_cyc(40 * Cpb);
        check("brk_ferr",  n_ferr - ferr0, 1);
        check("brk_busy",  busy_o, 1);
        check("brk_valid", valid_o, 0);
        rx_i = 1'b1;
        wait_cyc(10);
        check("brk_idle",  busy_o, 0);
        check("brk_ferr2", n_ferr - ferr0, 1);
        ready_i = 1'b1;
        popped.delete();
        send_frame(8'h12, ^8'h12, 1'b1);
        wait_cyc(10);
        check("brk_next_cnt", popped.size(), 1);
        check_pop("brk_next", 0, 8'h12);

        // Three-cycle glitch on an idle line.
        ferr0 = n_ferr;
        popped.delete();
        rx_i = 1'b0;
        wait_cyc(3);
        rx_i = 1'b1;
        wait_cyc(1);
        check("glt_busy", busy_o, 1);
        wait_cyc(30);
        check("glt_idle", busy_o, 0);
        check("glt_push", popped.size(), 0);
        check("glt_ferr", n_ferr - ferr0, 0);

`ifdef IGUANA_UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones so the parity bit must be 1.
        perr0 = n_perr;
        popped.delete();
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cyc(10);
        check("par_ok_cnt", popped.size(), 1);
        check_pop("par_ok", 0, 8'h07);
        check("par_ok_err", n_perr - perr0, 0);
        send_frame(8'h07, 1'b0, 1'b1);
        wait_cyc(10);
        check("par_bad_cnt", popped.size(), 1);
        check("par_bad_err", n_perr - perr0, 1);
`else
        check("perr_tied", n_perr, 0);
`endif

        // Reset in the middle of a frame with a byte already buffered.
        ready_i = 1'b0;
        ferr0 = n_ferr;
        perr0 = n_perr;
        ovf0  = n_ovf;
        send_frame(8'h77, ^8'h77, 1'b1);
        wait_cyc(3);
        check("mrst_pre", valid_o, 1);
        rx_i = 1'b0;
        wait_cyc(4 * Cpb);
        rst_ni = 1'b0;
        wait_cyc(2);
        check("mrst_valid", valid_o, 0);
        check("mrst_busy",  busy_o, 0);
        check("mrst_data",  data_o, 0);
        rx_i = 1'b1;
        rst_ni = 1'b1;
        wait_cyc(12 * Cpb);
        check("mrst_after", valid_o, 0);
        check("mrst_pulses", (n_ferr - ferr0) + (n_perr - perr0) + (n_ovf - ovf0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
